// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions for the QR array: widths, gain constant, state encoding and
// narrowing helpers. Define ROTATION_MODE_SAT_EN to saturate instead of wrap.
package cordic_pkg;

    localparam int unsigned DW   = 13;
    localparam int unsigned ITER = 8;
    localparam int unsigned IW   = $clog2(ITER);
    localparam int unsigned PW   = 25;
    localparam logic [9:0]  K    = 10'b1001101110;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExe  = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam logic signed [DW-1:0] MaxVal = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MinVal = {1'b1, {(DW-1){1'b0}}};

    // Narrow a 14-bit micro-rotation sum back to the data width.
    function automatic logic signed [DW-1:0] narrow(input logic signed [DW:0] s);
`ifdef ROTATION_MODE_SAT_EN
        if (s[DW] != s[DW-1]) begin
            narrow = s[DW] ? MinVal : MaxVal;
        end else begin
            narrow = {s[DW], s[DW-2:0]};
        end
`else
        narrow = {s[DW], s[DW-2:0]};
`endif
    endfunction

    // Multiply by K (Q0.10) and drop the fractional bits.
    function automatic logic signed [DW-1:0] gain(input logic signed [DW-1:0] x);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ke;
        logic signed [PW-1:0] p;
        xe = PW'(x);
        ke = PW'({1'b0, K});
        p  = xe * ke;
`ifdef ROTATION_MODE_SAT_EN
        if ((p[PW-1:PW-3] != 3'b000) && (p[PW-1:PW-3] != 3'b111)) begin
            gain = p[PW-1] ? MinVal : MaxVal;
        end else begin
            gain = {p[PW-1], p[PW-4:10]};
        end
`else
        gain = {p[PW-1], p[PW-4:10]};
`endif
    endfunction

endpackage

// File: rtl/cordic_pair_stage.sv
// Combinational pair of CORDIC micro-rotations: rotation iter then iter+1 on the narrowed
// intermediate result. Shared between vector and rotation mode.
module cordic_pair_stage
    import cordic_pkg::*;
(
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    input  logic [1:0]           dir,
    input  logic [IW-1:0]        iter,
    output logic signed [DW-1:0] x_next,
    output logic signed [DW-1:0] y_next
);

    logic [IW-1:0]        iter1;
    logic signed [DW-1:0] xsh0, ysh0, xsh1, ysh1, x1, y1;
    logic signed [DW:0]   sx0, sy0, sx1, sy1;

    always_comb begin
        iter1 = iter + IW'(1);
        xsh0  = x >>> iter;
        ysh0  = y >>> iter;
        // dir=1 rotates counter-clockwise
        sx0 = dir[0] ? ((DW+1)'(x) - (DW+1)'(ysh0)) : ((DW+1)'(x) + (DW+1)'(ysh0));
        sy0 = dir[0] ? ((DW+1)'(y) + (DW+1)'(xsh0)) : ((DW+1)'(y) - (DW+1)'(xsh0));
        x1  = narrow(sx0);
        y1  = narrow(sy0);

        xsh1 = x1 >>> iter1;
        ysh1 = y1 >>> iter1;
        sx1  = dir[1] ? ((DW+1)'(x1) - (DW+1)'(ysh1)) : ((DW+1)'(x1) + (DW+1)'(ysh1));
        sy1  = dir[1] ? ((DW+1)'(y1) + (DW+1)'(xsh1)) : ((DW+1)'(y1) - (DW+1)'(xsh1));
        x_next = narrow(sx1);
        y_next = narrow(sy1);
    end

endmodule

// File: rtl/rotation_mode.sv
// Givens-rotation stage: replays the vector-mode direction word on another element pair,
// two micro-rotations per cycle, then gain-compensates. ROTATION_MODE_SAT_EN selects saturation.
module rotation_mode
    import cordic_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] ori_X,
    input  logic signed [DW-1:0] ori_Y,
    input  logic [ITER-1:0]      sign_d,
    input  logic                 start,
    output logic                 ready,
    output logic signed [DW-1:0] rot_X,
    output logic signed [DW-1:0] rot_Y,
    output logic                 done
);

    state_t               state_q, state_d;
    logic signed [DW-1:0] x_q, x_d, y_q, y_d;
    logic [ITER-1:0]      dir_q, dir_d, dir_sh;
    logic [IW-1:0]        iter_q, iter_d;
    logic signed [DW-1:0] x_pair, y_pair;

    assign dir_sh = dir_q >> iter_q;

    cordic_pair_stage u_pair (
        .x      (x_q),
        .y      (y_q),
        .dir    (dir_sh[1:0]),
        .iter   (iter_q),
        .x_next (x_pair),
        .y_next (y_pair)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        iter_d  = iter_q;
        unique case (state_q)
            StIdle: begin
                // Inputs are tracked every idle cycle so the start-edge values are captured.
                x_d    = ori_X;
                y_d    = ori_Y;
                dir_d  = sign_d;
                iter_d = '0;
                if (start) state_d = StExe;
            end
            StExe: begin
                x_d    = x_pair;
                y_d    = y_pair;
                iter_d = iter_q + IW'(2);
                if (iter_q == IW'(ITER - 2)) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready = (state_q == StIdle);
        done  = (state_q == StDone);
        rot_X = done ? gain(x_q) : '0;
        rot_Y = done ? gain(y_q) : '0;
    end

endmodule

// File: doc/rotation_mode.md
Name: rotation_mode

Overview:
- Givens-rotation stage directly downstream of the vector-mode CORDIC in the QR-CORDIC array.
- Takes the 8-bit micro-rotation direction word (sign_d) produced by vector mode for the pivot pair.
- Applies the same 8 micro-rotations to another (X,Y) element pair of the two matrix rows, then applies gain compensation.
- Two micro-rotations per cycle: 4 EXE cycles plus 1 DONE cycle.

Parameters:
- K, 10'b1001101110, unsigned CORDIC gain compensation in Q0.10 (≈0.6074).
- DW, 13, signed data width, fixed-point Q2.10.
- ITER, 8, number of micro-rotations; must be even and must equal the sign_d width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ori_X  in  13  signed Q2.10 X element, sampled while in IDLE.
- ori_Y  in  13  signed Q2.10 Y element, sampled while in IDLE.
- sign_d  in  8  direction bits from vector mode; bit i=1 means counter-clockwise for iteration i; sampled while in IDLE.
- start  in  1  launch pulse; honoured only in IDLE.
- ready  out  1  high in IDLE; start is accepted only while ready=1.
- rot_X  out  13  signed Q2.10 result; valid only while done=1, otherwise 0.
- rot_Y  out  13  signed Q2.10 result; valid only while done=1, otherwise 0.
- done  out  1  one-cycle result-valid strobe.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-low. While reset=0: state=IDLE, all registers 0, ready=1, done=0, rot_X=rot_Y=0.
- States:
  - IDLE: start=1 → EXE; otherwise stay in IDLE. X/Y/dir registers load ori_X/ori_Y/sign_d every IDLE cycle, so the values present on the start edge are the ones used.
  - EXE: iter advances 0,2,4,6. When iter==6 → DONE.
  - DONE: unconditionally → IDLE.
- Latency: start sampled on edge t. EXE occupies cycles t+1..t+4. done=1 in cycle t+5. ready=1 again in cycle t+6.
- start outside IDLE is ignored, with no queueing. Minimum spacing between accepted starts is 6 cycles.
- Micro-rotation i uses d=dir[i]:
  - d=1: X' = X − (Y>>>i), Y' = Y + (X>>>i).
  - d=0: X' = X + (Y>>>i), Y' = Y − (X>>>i).
  - >>> is an arithmetic shift.
- Each EXE cycle performs rotation iter, then rotation iter+1 on the narrowed result.
- Width rules for each micro-rotation:
  - Sum formed at 14 bits (sign-extended operands).
  - Narrowed to 13 bits as {s[13], s[11:0]} (wrap, no saturation; see optional feature).
- Gain compensation in DONE: p = X × signed({1'b0,K}) at 25 bits; rot_X = {p[24], p[21:10]}. Same for Y.
- Reset mid-operation: the operation is abandoned and no done is produced.
- Edge inputs:
  - sign_d=0x00 and sign_d=0xFF are legal.
  - X=Y=0 yields 0 outputs with normal latency.

Optional Feature:
- Macro: ROTATION_MODE_SAT_EN.
- When defined: each 14-bit micro-rotation sum saturates to [−4096, 4095] instead of wrapping. The gain multiply also saturates if p[24:22] are not all equal to p[24].
- When undefined: wrap narrowing exactly as in Behaviour, bit-identical to the vector-mode arithmetic.

Decomposition:
- Shared package cordic_pkg holds:
  - DW, ITER, K.
  - State encoding: IDLE=2'd0, EXE=2'd1, DONE=2'd2.
  - The narrowing function (wrap/saturate), shared with vector mode.
- Sub-module cordic_pair_stage:
  - Combinational; inputs X, Y, two direction bits, shift base iter.
  - Outputs X, Y after rotations iter and iter+1.
  - Reusable by vector mode.

Test Plan:
- Reset/idle: reset=0 mid-EXE → next cycle state IDLE, done=0, rot_X=rot_Y=0, ready=1. No done follows.
- Clockwise: ori_X=1024, ori_Y=0, sign_d=0x00, start → done exactly at t+5 for one cycle. Expected rotation −99.45°: rot_X ≈ −168, rot_Y ≈ −1010 (±4 LSB vs bit-accurate golden model; exact match required).
- Counter-clockwise: same input with sign_d=0xFF → rot_X ≈ −168, rot_Y ≈ +1010 (±4 LSB), exact against golden model.
- Zero vector: X=Y=0, sign_d=0xA5 → rot_X=rot_Y=0, done at t+5. start held high continuously → accepted starts spaced 6 cycles apart.
- QR consistency: vector mode on (768, 512) produces sign_d. Rotation mode on the same (768, 512) with that sign_d → rot_Y within ±4 LSB of 0, and rot_X equal to the vector-mode rot_X.
- Overflow: X=Y=4000 with sign_d=0x00 vs 0xFF. Without ROTATION_MODE_SAT_EN, wrapped results must match the golden model. With the macro defined, results must clamp at 4095/−4096.
